// File: rtl/branch_pkg.sv
// Shared constants and types for the ID-stage branch hazard controller.
package branch_pkg;

  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_REGIMM = 6'h01;

  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_STALL, S_RESOLVE} state_t;

  function automatic logic is_branch_op(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLEZ) ||
           (op == OP_BGTZ) || (op == OP_REGIMM);
  endfunction

  // Only the two-register compares read rt.
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/branch_fwd_unit.sv
// Combinational operand-match, stall-requirement and forward-select logic for
// the ID-stage branch comparator.
module branch_fwd_unit
  import branch_pkg::*;
(
  input  logic       i_id_valid,
  input  logic [5:0] i_id_opcode,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_ex_regwrite,
  input  logic       i_ex_memread,
  input  logic [4:0] i_ex_rd,
  input  logic       i_mem_regwrite,
  input  logic       i_mem_memread,
  input  logic [4:0] i_mem_rd,
  input  logic       i_wb_regwrite,
  input  logic [4:0] i_wb_rd,
  output logic       o_is_branch,
  output logic [1:0] o_need,
  output logic [1:0] o_fwd_rs_sel,
  output logic [1:0] o_fwd_rt_sel
);

  logic w_use_rt;
  logic w_ex_rs, w_ex_rt, w_mem_rs, w_mem_rt, w_wb_rs, w_wb_rt;
  logic w_ex_hit, w_mem_hit;

  assign o_is_branch = i_id_valid && is_branch_op(i_id_opcode);
  assign w_use_rt    = uses_rt(i_id_opcode);

  // r0 is hardwired, so a producer targeting it never creates a dependency.
  assign w_ex_rs  = i_ex_regwrite  && (i_ex_rd  != 5'd0) && (i_ex_rd  == i_id_rs);
  assign w_ex_rt  = i_ex_regwrite  && (i_ex_rd  != 5'd0) && (i_ex_rd  == i_id_rt) && w_use_rt;
  assign w_mem_rs = i_mem_regwrite && (i_mem_rd != 5'd0) && (i_mem_rd == i_id_rs);
  assign w_mem_rt = i_mem_regwrite && (i_mem_rd != 5'd0) && (i_mem_rd == i_id_rt) && w_use_rt;
  assign w_wb_rs  = i_wb_regwrite  && (i_wb_rd  != 5'd0) && (i_wb_rd  == i_id_rs);
  assign w_wb_rt  = i_wb_regwrite  && (i_wb_rd  != 5'd0) && (i_wb_rd  == i_id_rt) && w_use_rt;

  assign w_ex_hit  = w_ex_rs  || w_ex_rt;
  assign w_mem_hit = w_mem_rs || w_mem_rt;

  always_comb begin
    o_need = 2'd0;
    if (o_is_branch) begin
      if (w_ex_hit && i_ex_memread)
        o_need = 2'd2;
      else if ((w_ex_hit && !i_ex_memread) || (w_mem_hit && i_mem_memread))
        o_need = 2'd1;
    end
  end

  // A load in EX/MEM has no data yet, so it can never be the forward source.
  always_comb begin
    o_fwd_rs_sel = FWD_RF;
    o_fwd_rt_sel = FWD_RF;
    if (o_is_branch) begin
      if (w_mem_rs && !i_mem_memread) o_fwd_rs_sel = FWD_EXMEM;
      else if (w_wb_rs)               o_fwd_rs_sel = FWD_MEMWB;
      if (w_mem_rt && !i_mem_memread) o_fwd_rt_sel = FWD_EXMEM;
      else if (w_wb_rt)               o_fwd_rt_sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch sequencer: stalls on comparator operand hazards, drives the
// forward selects, issues PC redirect / IF flush, and counts branch events.
module branch_hazard_ctrl
  import branch_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int DELAY_SLOT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [5:0]       id_opcode,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             mem_regwrite,
  input  logic             mem_memread,
  input  logic [4:0]       mem_rd,
  input  logic             wb_regwrite,
  input  logic [4:0]       wb_rd,
  input  logic             branch_taken,
  output logic             stall_if_id,
  output logic             bubble_ex,
  output logic             flush_if,
  output logic             pc_sel_branch,
  output logic [1:0]       fwd_rs_sel,
  output logic [1:0]       fwd_rt_sel,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state, w_next;
  logic [1:0]       r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_taken, r_stalls;
  logic             w_is_br, w_stall, w_resolve, w_pc_sel;
  logic [1:0]       w_need, w_fwd_rs, w_fwd_rt;

  branch_fwd_unit u_fwd (
    .i_id_valid     (id_valid),
    .i_id_opcode    (id_opcode),
    .i_id_rs        (id_rs),
    .i_id_rt        (id_rt),
    .i_ex_regwrite  (ex_regwrite),
    .i_ex_memread   (ex_memread),
    .i_ex_rd        (ex_rd),
    .i_mem_regwrite (mem_regwrite),
    .i_mem_memread  (mem_memread),
    .i_mem_rd       (mem_rd),
    .i_wb_regwrite  (wb_regwrite),
    .i_wb_rd        (wb_rd),
    .o_is_branch    (w_is_br),
    .o_need         (w_need),
    .o_fwd_rs_sel   (w_fwd_rs),
    .o_fwd_rt_sel   (w_fwd_rt)
  );

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    w_stall   = 1'b0;
    w_resolve = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_need != 2'd0) begin
          w_stall   = 1'b1;
          w_cnt_nxt = w_need - 2'd1;
          w_next    = (w_need == 2'd1) ? S_RESOLVE : S_STALL;
        end else if (w_is_br) begin
          w_resolve = 1'b1;
        end
      end
      S_STALL: begin
        w_stall = 1'b1;
        if (r_cnt != 2'd0) w_cnt_nxt = r_cnt - 2'd1;
        // <=1 rather than ==1 so a corrupted zero count cannot wedge the FSM.
        if (r_cnt <= 2'd1) w_next = S_RESOLVE;
      end
      S_RESOLVE: begin
        w_resolve = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (flush) begin
      w_next    = S_IDLE;
      w_cnt_nxt = 2'd0;
      w_stall   = 1'b0;
      w_resolve = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
    end else if (flush || !hold) begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_taken  <= '0;
      r_stalls <= '0;
    end else if (!hold && !flush) begin
      if (w_resolve && branch_taken && (r_taken != CNT_MAX)) r_taken  <= r_taken + CNT_ONE;
      if (w_stall && (r_stalls != CNT_MAX))                  r_stalls <= r_stalls + CNT_ONE;
    end
  end

  // Outputs are combinational, so they are gated by rst_n to read 0 during reset.
  assign w_pc_sel      = rst_n && w_resolve && branch_taken && !hold;
  assign pc_sel_branch = w_pc_sel;
  assign flush_if      = (DELAY_SLOT == 0) ? w_pc_sel : 1'b0;
  assign stall_if_id   = rst_n && w_stall;
  assign bubble_ex     = rst_n && w_stall;
  assign fwd_rs_sel    = (rst_n && !flush) ? w_fwd_rs : FWD_RF;
  assign fwd_rt_sel    = (rst_n && !flush) ? w_fwd_rt : FWD_RF;
  assign taken_cnt     = r_taken;
  assign stall_cnt     = r_stalls;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Vector-table and scoreboard bench for branch_hazard_ctrl (CNT_W=4, no delay slot).
module tb_branch_hazard_ctrl;

  localparam int CW = 4;

  logic          clk, rst_n, hold, flush, id_valid;
  logic [5:0]    id_opcode;
  logic [4:0]    id_rs, id_rt, ex_rd, mem_rd, wb_rd;
  logic          ex_regwrite, ex_memread, mem_regwrite, mem_memread, wb_regwrite;
  logic          branch_taken;
  logic          stall_if_id, bubble_ex, flush_if, pc_sel_branch;
  logic [1:0]    fwd_rs_sel, fwd_rt_sel;
  logic [CW-1:0] taken_cnt, stall_cnt;

  branch_hazard_ctrl #(.CNT_W(CW), .DELAY_SLOT(0)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
    .id_valid(id_valid), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_rd(mem_rd),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .branch_taken(branch_taken),
    .stall_if_id(stall_if_id), .bubble_ex(bubble_ex), .flush_if(flush_if),
    .pc_sel_branch(pc_sel_branch), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .taken_cnt(taken_cnt), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       hd, fl, vl;
    logic [5:0] op;
    logic [4:0] rs, rt;
    logic       exw, exl;
    logic [4:0] exrd;
    logic       mw, ml;
    logic [4:0] mrd;
    logic       ww;
    logic [4:0] wrd;
    logic       tk;
    logic       es, eb, ef, ep;
    logic [1:0] ers, ert;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_taken = 0;
  int   m_stall = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic hd, fl, vl, input logic [5:0] op, input logic [4:0] rs, rt,
                     input logic exw, exl, input logic [4:0] exrd,
                     input logic mw, ml, input logic [4:0] mrd,
                     input logic ww, input logic [4:0] wrd, input logic tk,
                     input logic es, eb, ef, ep, input logic [1:0] ers, ert);
    vec_t v;
    v.hd = hd; v.fl = fl; v.vl = vl; v.op = op; v.rs = rs; v.rt = rt;
    v.exw = exw; v.exl = exl; v.exrd = exrd; v.mw = mw; v.ml = ml; v.mrd = mrd;
    v.ww = ww; v.wrd = wrd; v.tk = tk;
    v.es = es; v.eb = eb; v.ef = ef; v.ep = ep; v.ers = ers; v.ert = ert;
    tbl.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    hold = v.hd; flush = v.fl; id_valid = v.vl; id_opcode = v.op; id_rs = v.rs; id_rt = v.rt;
    ex_regwrite = v.exw; ex_memread = v.exl; ex_rd = v.exrd;
    mem_regwrite = v.mw; mem_memread = v.ml; mem_rd = v.mrd;
    wb_regwrite = v.ww; wb_rd = v.wrd; branch_taken = v.tk;
  endtask

  task automatic idle_inputs();
    hold = 0; flush = 0; id_valid = 0; id_opcode = 0; id_rs = 0; id_rt = 0;
    ex_regwrite = 0; ex_memread = 0; ex_rd = 0; mem_regwrite = 0; mem_memread = 0; mem_rd = 0;
    wb_regwrite = 0; wb_rd = 0; branch_taken = 0;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, " stall"}, stall_if_id, 0);
    chk({tag, " bubble"}, bubble_ex, 0);
    chk({tag, " flush_if"}, flush_if, 0);
    chk({tag, " pc_sel"}, pc_sel_branch, 0);
    chk({tag, " fwd_rs"}, fwd_rs_sel, 0);
    chk({tag, " fwd_rt"}, fwd_rt_sel, 0);
    chk({tag, " taken_cnt"}, taken_cnt, 0);
    chk({tag, " stall_cnt"}, stall_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t e;
    // hd fl vl op rs rt | exw exl exrd | mw ml mrd | ww wrd | tk | stall bub fif pcs frs frt
    add(0,0,1,6'h04, 1, 2, 0,0, 0, 0,0, 0, 0, 0, 1, 0,0,1,1,0,0);  // beq, no producers
    add(0,0,0,6'h00, 0, 0, 0,0, 0, 0,0, 0, 0, 0, 0, 0,0,0,0,0,0);
    add(0,0,1,6'h05, 3, 4, 1,1, 3, 0,0, 0, 0, 0, 0, 1,1,0,0,0,0);  // lw r3 -> bne r3,r4
    add(0,0,1,6'h05, 3, 4, 0,0, 0, 1,1, 3, 0, 0, 1, 1,1,0,0,0,0);
    add(0,0,1,6'h05, 3, 4, 0,0, 0, 0,0, 0, 1, 3, 1, 0,0,1,1,2,0);
    add(0,0,1,6'h07, 5, 5, 1,0, 5, 0,0, 0, 0, 0, 0, 1,1,0,0,0,0);  // add r5 -> bgtz r5
    add(0,0,1,6'h07, 5, 5, 0,0, 0, 1,0, 5, 0, 0, 1, 0,0,1,1,1,0);
    add(0,0,1,6'h04, 0, 0, 1,0, 0, 1,0, 0, 1, 0, 0, 0,0,0,0,0,0);  // r0 never matches
    add(0,0,1,6'h00, 3, 3, 1,1, 3, 1,0, 3, 0, 0, 1, 0,0,0,0,0,0);  // non-branch
    add(0,0,0,6'h04, 3, 3, 1,1, 3, 1,0, 3, 0, 0, 1, 0,0,0,0,0,0);  // invalid ID
    add(0,0,1,6'h04,13,14, 0,0, 0, 1,0,14, 1,13, 0, 0,0,0,0,2,1);
    add(0,0,1,6'h04,13,13, 0,0, 0, 1,0,13, 1,13, 0, 0,0,0,0,1,1);  // EX/MEM wins
    add(0,0,1,6'h04, 6, 7, 1,1, 6, 1,1, 7, 0, 0, 0, 1,1,0,0,0,0);  // need=max(2,1)
    add(0,1,1,6'h04, 6, 7, 1,1, 6, 1,1, 7, 1, 7, 1, 0,0,0,0,0,0);  // flush in STALL
    add(0,0,1,6'h04,20,21, 0,0, 0, 0,0, 0, 0, 0, 1, 0,0,1,1,0,0);  // back in IDLE
    add(0,0,1,6'h04, 8, 9, 1,1, 9, 0,0, 0, 0, 0, 0, 1,1,0,0,0,0);
    add(1,0,1,6'h04, 8, 9, 0,0, 0, 1,1, 9, 0, 0, 1, 1,1,0,0,0,0);  // hold in STALL
    add(0,0,1,6'h04, 8, 9, 0,0, 0, 1,1, 9, 0, 0, 0, 1,1,0,0,0,0);
    add(1,0,1,6'h04, 8, 9, 0,0, 0, 0,0, 0, 1, 9, 1, 0,0,0,0,0,2);  // hold in RESOLVE
    add(0,0,1,6'h04, 8, 9, 0,0, 0, 0,0, 0, 1, 9, 1, 0,0,1,1,0,2);
    add(0,0,1,6'h01,10,11, 1,0,11, 1,0,11, 0, 0, 1, 0,0,1,1,0,0);  // regimm ignores rt
    add(0,0,1,6'h06,12,12, 0,0, 0, 1,1,12, 0, 0, 0, 1,1,0,0,0,0);  // blez, EX/MEM load
    add(0,0,1,6'h06,12,12, 0,0, 0, 0,0, 0, 1,12, 0, 0,0,0,0,2,0);
    add(1,0,1,6'h04, 3, 0, 1,0, 3, 0,0, 0, 0, 0, 0, 1,1,0,0,0,0);  // hold in IDLE
    add(0,0,1,6'h04, 3, 0, 1,0, 3, 0,0, 0, 0, 0, 0, 1,1,0,0,0,0);
    add(0,0,1,6'h04, 3, 0, 0,0, 0, 1,0, 3, 0, 0, 0, 0,0,0,0,1,0);
    for (int r = 0; r < 6; r++) begin  // drives stall_cnt into saturation
      add(0,0,1,6'h04, 3, 4, 1,1, 3, 0,0, 0, 0, 0, 0, 1,1,0,0,0,0);
      add(0,0,1,6'h04, 3, 4, 0,0, 0, 1,1, 3, 0, 0, 0, 1,1,0,0,0,0);
      add(0,0,1,6'h04, 3, 4, 0,0, 0, 0,0, 0, 1, 3, 1, 0,0,1,1,2,0);
    end

    // Reset: hazard-laden inputs must not leak through while rst_n is low.
    rst_n = 1'b0;
    idle_inputs();
    id_valid = 1; id_opcode = 6'h04; id_rs = 3; id_rt = 4;
    ex_regwrite = 1; ex_memread = 1; ex_rd = 3;
    mem_regwrite = 1; mem_rd = 4; branch_taken = 1;
    #12;
    all_zero("reset");
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      apply(tbl[i]);
      exp_q.push_back(tbl[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      chk($sformatf("v%0d stall", i), stall_if_id, e.es);
      chk($sformatf("v%0d bubble", i), bubble_ex, e.eb);
      chk($sformatf("v%0d flush_if", i), flush_if, e.ef);
      chk($sformatf("v%0d pc_sel", i), pc_sel_branch, e.ep);
      chk($sformatf("v%0d fwd_rs", i), fwd_rs_sel, e.ers);
      chk($sformatf("v%0d fwd_rt", i), fwd_rt_sel, e.ert);
      chk($sformatf("v%0d taken_cnt", i), taken_cnt, m_taken);
      chk($sformatf("v%0d stall_cnt", i), stall_cnt, m_stall);
      if (!e.hd && !e.fl) begin
        if (e.es && m_stall < 15) m_stall++;
        if (e.ep && m_taken < 15) m_taken++;
      end
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("sat stall_cnt", stall_cnt, 15);
    chk("final taken_cnt", taken_cnt, m_taken);

    // Reset asserted mid-STALL aborts asynchronously; ID is re-evaluated after release.
    @(posedge clk); #1;
    id_valid = 1; id_opcode = 6'h04; id_rs = 3; id_rt = 4;
    ex_regwrite = 1; ex_memread = 1; ex_rd = 3;
    @(negedge clk);
    chk("pre-rst stall", stall_if_id, 1);
    @(posedge clk); #1;
    ex_regwrite = 0; ex_memread = 0; ex_rd = 0;
    mem_regwrite = 1; mem_memread = 1; mem_rd = 3;
    #1;
    chk("in STALL stall", stall_if_id, 1);
    rst_n = 1'b0;
    #1;
    all_zero("mid-stall reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-rst stall", stall_if_id, 1);
    chk("post-rst stall_cnt", stall_cnt, 0);
    @(posedge clk); #1;
    mem_regwrite = 0; mem_memread = 0; mem_rd = 0;
    wb_regwrite = 1; wb_rd = 3; branch_taken = 1;
    @(negedge clk);
    chk("post-rst pc_sel", pc_sel_branch, 1);
    chk("post-rst fwd_rs", fwd_rs_sel, 2);
    chk("post-rst stall_cnt", stall_cnt, 1);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("post-rst taken_cnt", taken_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_hazard_ctrl.md
Name: branch_hazard_ctrl

Overview:
- Sequences the ID-stage branch comparator of the 5-stage MIPS32 pipeline.
- Detects data hazards on the comparator operands (rs, rt) and inserts the required stall cycles.
- Selects the forwarding source for each operand, then issues the PC redirect and IF flush once the comparator result is valid.
- Keeps saturating statistics counters for taken branches and branch-induced stalls.

Parameters:
- CNT_W, 32: width of the statistics counters.
- DELAY_SLOT, 0: 1 = MIPS delay slot is architectural; flush_if is never asserted.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- hold  in  1  global pipeline freeze; FSM, counters and outputs hold
- flush  in  1  exception/eret flush; FSM returns to IDLE
- id_valid  in  1  IF/ID holds a valid instruction
- id_opcode  in  6  opcode in ID
- id_rs  in  5  rs field in ID
- id_rt  in  5  rt field in ID
- ex_regwrite  in  1  ID/EX instruction writes a register
- ex_memread  in  1  ID/EX instruction is a load
- ex_rd  in  5  ID/EX destination register
- mem_regwrite  in  1  EX/MEM writes a register
- mem_memread  in  1  EX/MEM is a load
- mem_rd  in  5  EX/MEM destination register
- wb_regwrite  in  1  MEM/WB writes a register
- wb_rd  in  5  MEM/WB destination register
- branch_taken  in  1  comparator output, computed on the forwarded operands
- stall_if_id  out  1  hold PC and IF/ID
- bubble_ex  out  1  load a NOP into ID/EX
- flush_if  out  1  squash the instruction entering IF/ID
- pc_sel_branch  out  1  PC takes the branch target this cycle
- fwd_rs_sel  out  2  0 = register file, 1 = EX/MEM ALU result, 2 = MEM/WB write data
- fwd_rt_sel  out  2  same encoding, for rt
- taken_cnt  out  CNT_W  number of taken branches
- stall_cnt  out  CNT_W  number of branch stall cycles

Behaviour:
- Branch opcodes are 0x04, 0x05, 0x06, 0x07 and 0x01.
- rt is a used source only for 0x04 and 0x05; rs is used by all branch opcodes.
- A "match" requires the producer's regwrite=1, its destination equal to a used source, and a destination other than 0.
- Stall requirement, need:
  - 2 if ID/EX is a load that matches.
  - Otherwise 1 if ID/EX is a non-load that matches, or EX/MEM is a load that matches.
  - Otherwise 0.
- Forward selection (combinational), EX/MEM before MEM/WB:
  - sel=1 if a non-load in EX/MEM matches the operand.
  - Otherwise sel=2 if MEM/WB matches.
  - Otherwise 0.
  - sel is 0 for non-branch instructions.
- States are IDLE, STALL and RESOLVE. A cnt register, 2 bits wide, holds the remaining stall cycles.
- IDLE:
  - If id_valid, the opcode is a branch and need=0: resolve this cycle.
  - If need>0: assert stall_if_id and bubble_ex, load cnt=need-1. Go to RESOLVE if need=1, otherwise to STALL.
- STALL:
  - Assert stall_if_id and bubble_ex, decrement cnt.
  - Go to RESOLVE when cnt=1 at entry.
- RESOLVE:
  - Resolve this cycle, with no stall. Next state is IDLE.
- Resolve cycle behaviour:
  - pc_sel_branch = branch_taken.
  - flush_if = branch_taken & (DELAY_SLOT==0).
- Total branch latency in ID is need+1 cycles.
- Outputs are Mealy and combinational from state and inputs. The FSM, cnt and the counters are registered.
- hold=1: no state, cnt or counter update; stall_if_id is still driven as computed; pc_sel_branch and flush_if are forced to 0.
- flush=1, with priority over hold: the next state is IDLE and all outputs are 0 in that cycle. No counter increments.
- taken_cnt increments on each resolve cycle with branch_taken=1.
- stall_cnt increments on each cycle with stall_if_id=1.
- Both counters saturate at all-ones and never wrap.
- While rst_n=0:
  - state = IDLE, cnt = 0.
  - Every output is 0, including both counters.
- Reset asserted mid-stall aborts immediately. After release, the ID instruction is re-evaluated from IDLE.
- Simultaneous ID/EX load match on rs and EX/MEM load match on rt: need = 2, the maximum of the two requirements.

Decomposition:
- Shared package branch_pkg holds:
  - opcode constants OP_BEQ=0x04, OP_BNE=0x05, OP_BLEZ=0x06, OP_BGTZ=0x07, OP_REGIMM=0x01.
  - forwarding encodings FWD_RF=0, FWD_EXMEM=1, FWD_MEMWB=2.
  - the FSM state enum.
- One sub-module, branch_fwd_unit: purely combinational match, need and forward-select logic, instantiated once. The FSM and counters live in the top module.

Test Plan:
- beq r1,r2 with no producers, branch_taken=1 -> 1 cycle: pc_sel_branch=1, flush_if=1, fwd 0/0, taken_cnt 0->1, stall_cnt unchanged.
- lw r3 in ID/EX (ex_memread=1, ex_rd=3), then bne r3,r4 -> 2 cycles of stall_if_id=bubble_ex=1 and stall_cnt +2. In the RESOLVE cycle (mem_regwrite=0, wb_rd=3): fwd_rs_sel=2, pc_sel_branch=branch_taken.
- add r5 in ID/EX (ex_rd=5), then bgtz r5 -> 1 stall cycle. RESOLVE with mem_rd=5 non-load: fwd_rs_sel=1, fwd_rt_sel=0 (rt unused).
- ex_rd=0 with ex_regwrite=1, then beq r0,r0 -> no stall, fwd 0/0.
- flush=1 in the STALL cycle -> next cycle IDLE with all outputs 0. hold=1 during STALL -> cnt and stall_cnt frozen.
- Preload stall_cnt to all-ones via a long stall sequence (CNT_W=4): the 16th stall cycle keeps it at 15. rst_n low mid-STALL -> all outputs 0 asynchronously.
